// File: rtl/sha256_round_ctrl.sv
// SHA-256 main-loop round sequencer.
// Accepts one 512-bit block per blk_valid_i/blk_ready_o handshake and walks the
// interleaved compression pipeline through ROUNDS rounds of ROUND_CYCLES clocks,
// a DRAIN_CYCLES pipeline flush, and a hash-update strobe. After the last block
// of a message it holds digest_valid_o until the consumer takes the digest.
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   blk_valid_i/_ready_o  block handshake; blk_first_i/blk_last_i sampled with it
//   clr_o                 one-cycle strobe: reload initial hash into the datapath
//   update_o              one-cycle strobe: fold working state into the hash
//   busy_o                high whenever the controller is not idle
//   round_o, k_o          round index t and round constant K[t]
//   w_msg_sel_o           1: W from the message word (t<16), 0: from the expander
//   w_adv_o               advance the message scheduler by one word
//   digest_valid_o/digest_ready_i  digest handshake
module sha256_round_ctrl #(
  parameter int unsigned ROUNDS       = 64,
  parameter int unsigned ROUND_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        blk_valid_i,
  input  logic        blk_first_i,
  input  logic        blk_last_i,
  output logic        blk_ready_o,
  output logic        clr_o,
  output logic        update_o,
  output logic        busy_o,
  output logic [5:0]  round_o,
  output logic [31:0] k_o,
  output logic        w_msg_sel_o,
  output logic        w_adv_o,
  output logic        digest_valid_o,
  input  logic        digest_ready_i
);

  localparam int unsigned ROUND_W    = 6;
  localparam int unsigned RUN_CYCLES = ROUNDS * ROUND_CYCLES;
  localparam int unsigned CNT_MAX    = (RUN_CYCLES > DRAIN_CYCLES) ? RUN_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX);
  // ROUND_CYCLES is a power of two, so cnt/ROUND_CYCLES is a right shift
  localparam int unsigned RC_SHIFT   = $clog2(ROUND_CYCLES);

  localparam logic [CNT_W-1:0]   RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PHASE_MASK = CNT_W'(ROUND_CYCLES - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);
  localparam logic [ROUND_W-1:0] MSG_ROUNDS = ROUND_W'(16);

  // FIPS 180-4 round constants
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [ROUND_W-1:0] run_round;

  assign run_round = ROUND_W'(cnt_q >> RC_SHIFT);

  // State, cycle counter and latched block flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // Next state and Moore output decode
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    first_d        = first_q;
    last_d         = last_q;
    blk_ready_o    = 1'b0;
    clr_o          = 1'b0;
    update_o       = 1'b0;
    round_o        = '0;
    w_adv_o        = 1'b0;
    digest_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin
          first_d = blk_first_i;
          last_d  = blk_last_i;
          cnt_d   = '0;
          state_d = blk_first_i ? CLEAR : RUN;
        end
      end
      CLEAR: begin
        // only entered for a first block, so this is always a single pulse
        clr_o   = first_q;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        round_o = run_round;
        w_adv_o = ((cnt_q & PHASE_MASK) == PHASE_MASK);
        if (cnt_q == RUN_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        round_o = LAST_ROUND;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UPDATE: begin
        round_o  = LAST_ROUND;
        update_o = 1'b1;
        state_d  = last_q ? DONE : IDLE;
      end
      DONE: begin
        round_o        = LAST_ROUND;
        digest_valid_o = 1'b1;
        if (digest_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign k_o         = K_ROM[round_o];
  assign w_msg_sel_o = (round_o < MSG_ROUNDS);

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: single block with digest backpressure,
// two-block message, asynchronous abort, and back-to-back non-first blocks.
module tb_sha256_round_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        blk_valid, blk_first, blk_last, blk_ready;
  logic        clr, update, busy, w_msg_sel, w_adv, dv, digest_ready;
  logic [5:0]  round;
  logic [31:0] k;

  int n_cmp = 0;
  int n_err = 0;
  int clr_seen = 0;
  int upd_seen = 0;
  int dv_seen  = 0;

  sha256_round_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .blk_valid_i    (blk_valid),
    .blk_first_i    (blk_first),
    .blk_last_i     (blk_last),
    .blk_ready_o    (blk_ready),
    .clr_o          (clr),
    .update_o       (update),
    .busy_o         (busy),
    .round_o        (round),
    .k_o            (k),
    .w_msg_sel_o    (w_msg_sel),
    .w_adv_o        (w_adv),
    .digest_valid_o (dv),
    .digest_ready_i (digest_ready)
  );

  always #5 clk = ~clk;

  // Strobe tallies, sampled mid-cycle
  always @(negedge clk) begin
    if (clr === 1'b1)    clr_seen++;
    if (update === 1'b1) upd_seen++;
    if (dv === 1'b1)     dv_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake one block from IDLE and walk it to completion
  task automatic run_block(input logic first, input logic last);
    int pulses;
    logic [31:0] exp_k;
    pulses = 0;
    blk_first = first;
    blk_last  = last;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    if (first) begin
      chk("clear_strobe", 32'(clr), 32'd1);
      chk("clear_busy", 32'(busy), 32'd1);
      chk("clear_ready", 32'(blk_ready), 32'd0);
      step();
    end
    for (int i = 0; i < 256; i++) begin
      chk("run_round", 32'(round), 32'(i / 4));
      chk("run_w_adv", 32'(w_adv), 32'((i % 4) == 3));
      chk("run_strobes", {30'd0, clr, update}, 32'd0);
      if (w_adv === 1'b1) pulses++;
      if (i == 0 || i == 4 || i == 64 || i == 252) begin
        case (i)
          0:       exp_k = 32'h428a2f98;
          4:       exp_k = 32'h71374491;
          64:      exp_k = 32'he49b69c1;
          default: exp_k = 32'hc67178f2;
        endcase
        chk("run_k", k, exp_k);
      end
      if (i == 60 || i == 64) chk("run_msel", 32'(w_msg_sel), 32'(i == 60));
      step();
    end
    chk("w_adv_pulses", 32'(pulses), 32'd64);
    for (int d = 0; d < 4; d++) begin
      chk("drain_round", 32'(round), 32'd63);
      chk("drain_w_adv", 32'(w_adv), 32'd0);
      chk("drain_update", 32'(update), 32'd0);
      step();
    end
    chk("update_strobe", 32'(update), 32'd1);
    chk("update_busy", 32'(busy), 32'd1);
    step();
    chk("post_update_dv", 32'(dv), 32'(last));
    chk("post_update_ready", 32'(blk_ready), 32'(!last));
    chk("post_update_strobe", 32'(update), 32'd0);
  endtask

  initial begin
    int c0, u0, d0, n;
    rst = 1'b1;
    blk_valid = 1'b0;
    blk_first = 1'b0;
    blk_last = 1'b0;
    digest_ready = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(blk_ready), 32'd1);
    chk("rst_strobes", {29'd0, clr, update, w_adv}, 32'd0);
    chk("rst_dv", 32'(dv), 32'd0);
    chk("rst_round", 32'(round), 32'd0);
    chk("rst_k", k, 32'h428a2f98);
    rst = 1'b0;
    step();

    // Single block with digest backpressure
    run_block(1'b1, 1'b1);
    blk_valid = 1'b1;
    blk_first = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("bp_dv", 32'(dv), 32'd1);
      chk("bp_ready", 32'(blk_ready), 32'd0);
      chk("bp_strobes", {30'd0, clr, update}, 32'd0);
      step();
    end
    blk_valid = 1'b0;
    digest_ready = 1'b1;
    step();
    digest_ready = 1'b0;
    chk("bp_release_dv", 32'(dv), 32'd0);
    chk("bp_release_ready", 32'(blk_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("single_clr_count", 32'(clr_seen), 32'd1);
    chk("single_upd_count", 32'(upd_seen), 32'd1);

    // Two-block message
    c0 = clr_seen;
    u0 = upd_seen;
    d0 = dv_seen;
    run_block(1'b1, 1'b0);
    chk("two_mid_busy", 32'(busy), 32'd0);
    chk("two_mid_dv_count", 32'(dv_seen - d0), 32'd0);
    run_block(1'b0, 1'b1);
    chk("two_clr_count", 32'(clr_seen - c0), 32'd1);
    chk("two_upd_count", 32'(upd_seen - u0), 32'd2);
    digest_ready = 1'b1;
    step();
    digest_ready = 1'b0;
    chk("two_idle", 32'(busy), 32'd0);

    // Asynchronous abort at round 30
    blk_first = 1'b1;
    blk_last = 1'b1;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    step();
    for (int i = 0; i < 120; i++) step();
    chk("abort_pre_round", 32'(round), 32'd30);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_round", 32'(round), 32'd0);
    chk("abort_ready", 32'(blk_ready), 32'd1);
    chk("abort_outs", {28'd0, clr, update, w_adv, dv}, 32'd0);
    #2 rst = 1'b0;
    u0 = upd_seen;
    d0 = dv_seen;
    for (int i = 0; i < 300; i++) step();
    chk("abort_no_update", 32'(upd_seen - u0), 32'd0);
    chk("abort_no_dv", 32'(dv_seen - d0), 32'd0);
    run_block(1'b1, 1'b1);
    digest_ready = 1'b1;
    step();
    digest_ready = 1'b0;

    // Back-to-back non-first blocks with valid held high
    c0 = clr_seen;
    blk_first = 1'b0;
    blk_last = 1'b0;
    blk_valid = 1'b1;
    step();
    chk("b2b_start_busy", 32'(busy), 32'd1);
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (busy === 1'b1 && n < 400) begin
        n++;
        step();
      end
      chk("b2b_busy_len", 32'(n), 32'd261);
      chk("b2b_idle_ready", 32'(blk_ready), 32'd1);
      step();
      chk("b2b_restart_busy", 32'(busy), 32'd1);
      chk("b2b_restart_round", 32'(round), 32'd0);
    end
    blk_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      step();
    end
    chk("b2b_final_idle", 32'(busy), 32'd0);
    chk("b2b_no_clr", 32'(clr_seen - c0), 32'd0);
    chk("b2b_no_dv", 32'(dv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
